// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and scanout FSM state encoding,
// used by both the framebuffer writer and the scanout side.
package fb_pkg;
  localparam int FB_COLS     = 64;
  localparam int FB_ROWS     = 64;
  localparam int FB_AW       = 12;
  localparam int PIX_W       = 8;
  localparam int SCALE_SHIFT = 2;
  localparam int H_VISIBLE   = 256;

  localparam int COL_W = $clog2(FB_COLS);
  localparam int ROW_W = $clog2(FB_ROWS);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } fill_state_t;
endpackage

// File: rtl/fb_linebuf.sv
// Two-bank, 64-entry line buffer: one write port fed by framebuffer
// reads, one registered read port feeding the pixel output.
import fb_pkg::*;

module fb_linebuf (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [COL_W-1:0] wr_col,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [COL_W-1:0] rd_col,
  output logic [PIX_W-1:0] rd_data
);
  logic [PIX_W-1:0] mem [0:2*FB_COLS-1];

  // Contents deliberately survive reset; only the read register is clocked.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_col}] <= wr_data;
    end
    rd_data <= mem[{rd_bank, rd_col}];
  end
endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: prefetches one 64-byte framebuffer row per 4 lines into
// a double-buffered line buffer and emits 4x-scaled pixel colour.
import fb_pkg::*;

module fb_scanout #(
  parameter int V_TOTAL = 262,
  parameter int FILL_H  = 0,
  parameter int RD_LAT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             display_on,
  input  logic [8:0]       hpos,
  input  logic [8:0]       vpos,
  output logic             rd_en,
  output logic [FB_AW-1:0] addr,
  input  logic [PIX_W-1:0] ram_q,
  output logic             fb_busy,
  output logic [PIX_W-1:0] pixel,
  output logic             pixel_valid,
  output logic             fill_overrun
);
  fill_state_t      state_reg, state_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic             trigger;
  logic [ROW_W-1:0] trig_row;
  logic             pending;
  logic             fill_overrun_reg;
  logic             pixel_valid_reg;
  logic             disp;
  logic [PIX_W-1:0] lb_q;
  logic             tag_valid_reg [RD_LAT];
  logic [COL_W-1:0] tag_col_reg   [RD_LAT];

  // Trigger lines are decoded directly so vpos+1 never has to be formed.
  always_comb begin
    trigger  = 1'b0;
    trig_row = '0;
    if (hpos == 9'(FILL_H)) begin
      if (vpos == 9'(V_TOTAL - 1)) begin
        trigger = 1'b1;
      end else if ((vpos < 9'(H_VISIBLE - 1)) && (vpos[1:0] == 2'b11)) begin
        trigger  = 1'b1;
        trig_row = vpos[SCALE_SHIFT +: ROW_W] + ROW_W'(1);
      end
    end
  end

  // Reads still in flight beyond the one returning this cycle.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      pending = pending | tag_valid_reg[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    rd_en      = 1'b0;
    addr       = '0;
    fb_busy    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (trigger) begin
          row_next   = trig_row;
          col_next   = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        rd_en   = 1'b1;
        addr    = {row_reg, col_reg};
        fb_busy = 1'b1;
        if (col_reg == COL_W'(FB_COLS - 1)) begin
          col_next   = '0;
          state_next = DRAIN;
        end else begin
          col_next = col_reg + COL_W'(1);
        end
      end
      DRAIN: begin
        fb_busy = 1'b1;
        if (!pending) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg        <= IDLE;
      row_reg          <= '0;
      col_reg          <= '0;
      fill_overrun_reg <= 1'b0;
      pixel_valid_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      row_reg         <= row_next;
      col_reg         <= col_next;
      pixel_valid_reg <= disp;
      if (trigger && (state_reg != IDLE)) begin
        fill_overrun_reg <= 1'b1;
      end
    end
  end

  // Column tags travel alongside the RAM latency so data lands in the right slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_valid_reg[i] <= 1'b0;
        tag_col_reg[i]   <= '0;
      end
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        tag_valid_reg[i] <= tag_valid_reg[i-1];
        tag_col_reg[i]   <= tag_col_reg[i-1];
      end
      tag_valid_reg[0] <= rd_en;
      tag_col_reg[0]   <= col_reg;
    end
  end

  assign disp = display_on && (hpos < 9'(H_VISIBLE)) && (vpos < 9'(H_VISIBLE));

  fb_linebuf u_linebuf (
    .clk     (clk),
    .wr_en   (tag_valid_reg[RD_LAT-1]),
    .wr_bank (row_reg[0]),
    .wr_col  (tag_col_reg[RD_LAT-1]),
    .wr_data (ram_q),
    .rd_bank (vpos[SCALE_SHIFT]),
    .rd_col  (hpos[SCALE_SHIFT +: COL_W]),
    .rd_data (lb_q)
  );

  assign pixel        = pixel_valid_reg ? lb_q : '0;
  assign pixel_valid  = pixel_valid_reg;
  assign fill_overrun = fill_overrun_reg;
endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: two instances (read latency 1 and 2) share
// stimulus; expected addresses and pixels flow through scoreboard queues.
module tb_fb_scanout;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        display_on = 1'b0;
  logic [8:0]  hpos = 9'd1;
  logic [8:0]  vpos = 9'd100;

  logic        rd_en1, rd_en2, fb_busy1, fb_busy2;
  logic [11:0] addr1, addr2;
  logic [7:0]  ram_q1, ram_q2, pixel1, pixel2, q2a;
  logic        pixel_valid1, pixel_valid2, fill_overrun1, fill_overrun2;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_addr1[$];
  int exp_addr2[$];
  logic [8:0] exp_pix[$];

  always #5 clk = ~clk;

  fb_scanout #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .display_on(display_on), .hpos(hpos), .vpos(vpos),
    .rd_en(rd_en1), .addr(addr1), .ram_q(ram_q1), .fb_busy(fb_busy1),
    .pixel(pixel1), .pixel_valid(pixel_valid1), .fill_overrun(fill_overrun1)
  );

  fb_scanout #(.RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .display_on(display_on), .hpos(hpos), .vpos(vpos),
    .rd_en(rd_en2), .addr(addr2), .ram_q(ram_q2), .fb_busy(fb_busy2),
    .pixel(pixel2), .pixel_valid(pixel_valid2), .fill_overrun(fill_overrun2)
  );

  // Framebuffer model: byte (r*64+c) = r^c; junk when no read so skew shows up.
  function automatic logic [7:0] ram_val(input logic [11:0] a);
    return {2'b00, a[11:6] ^ a[5:0]};
  endfunction

  always @(posedge clk) begin
    ram_q1 <= rd_en1 ? ram_val(addr1) : 8'hEE;
    q2a    <= rd_en2 ? ram_val(addr2) : 8'hEE;
    ram_q2 <= q2a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pix_step(input logic [8:0] v, input logic [8:0] h, input logic don,
                          input logic [8:0] exp);
    logic [8:0] e;
    vpos = v; hpos = h; display_on = don;
    exp_pix.push_back(exp);
    tick();
    e = exp_pix.pop_front();
    chk($sformatf("pix1 v%0d h%0d", v, h), {23'd0, pixel_valid1, pixel1}, {23'd0, e});
    chk($sformatf("pix2 v%0d h%0d", v, h), {23'd0, pixel_valid2, pixel2}, {23'd0, e});
    $display("[TB] pixel v=%0d h=%0d -> valid=%0b pix=0x%02h", v, h, pixel_valid1, pixel1);
  endtask

  task automatic run_fill(input logic [8:0] tv, input int row, input int inject_at,
                          input int abort_col, input logic exp_ovr);
    int rd1, rd2, busy1, busy2, e;
    bit aborted;
    rd1 = 0; rd2 = 0; busy1 = 0; busy2 = 0; aborted = 0;
    exp_addr1.delete();
    exp_addr2.delete();
    for (int c = 0; c < 64; c++) begin
      exp_addr1.push_back(row * 64 + c);
      exp_addr2.push_back(row * 64 + c);
    end
    display_on = 1'b0; vpos = tv; hpos = 9'd0;
    tick();
    hpos = 9'd1;
    for (int k = 0; k < 90 && !aborted; k++) begin
      if (fb_busy1) busy1++;
      if (fb_busy2) busy2++;
      if (rd_en1) begin
        rd1++;
        if (exp_addr1.size() == 0) chk("addr1_extra_read", 1, 0);
        else begin e = exp_addr1.pop_front(); chk("addr1", {20'd0, addr1}, e); end
      end
      if (rd_en2) begin
        rd2++;
        if (exp_addr2.size() == 0) chk("addr2_extra_read", 1, 0);
        else begin e = exp_addr2.pop_front(); chk("addr2", {20'd0, addr2}, e); end
      end
      if (abort_col >= 0 && rd_en1 && int'(addr1[5:0]) == abort_col) begin
        reset = 1'b0;
        tick();
        chk("abort_rd_en1", {31'd0, rd_en1}, 0);
        chk("abort_busy1", {31'd0, fb_busy1}, 0);
        chk("abort_addr1", {20'd0, addr1}, 0);
        chk("abort_rd_en2", {31'd0, rd_en2}, 0);
        chk("abort_busy2", {31'd0, fb_busy2}, 0);
        chk("abort_ovr1", {31'd0, fill_overrun1}, 0);
        reset = 1'b1;
        aborted = 1;
      end else begin
        hpos = (k == inject_at) ? 9'd0 : 9'd1;
        tick();
      end
    end
    if (!aborted) begin
      chk("reads1", rd1, 64);
      chk("reads2", rd2, 64);
      chk("busy1", busy1, 65);
      chk("busy2", busy2, 66);
      chk("missing1", exp_addr1.size(), 0);
      chk("missing2", exp_addr2.size(), 0);
      chk("ovr1", {31'd0, fill_overrun1}, {31'd0, exp_ovr});
      chk("ovr2", {31'd0, fill_overrun2}, {31'd0, exp_ovr});
    end
    $display("[TB] fill row %0d: reads %0d/%0d busy %0d/%0d aborted=%0b",
             row, rd1, rd2, busy1, busy2, aborted);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_rd_en1", {31'd0, rd_en1}, 0);
    chk("rst_addr1", {20'd0, addr1}, 0);
    chk("rst_busy1", {31'd0, fb_busy1}, 0);
    chk("rst_pixel1", {23'd0, pixel_valid1, pixel1}, 0);
    chk("rst_ovr1", {31'd0, fill_overrun1}, 0);
    chk("rst_rd_en2", {31'd0, rd_en2}, 0);
    chk("rst_busy2", {31'd0, fb_busy2}, 0);
    chk("rst_pixel2", {23'd0, pixel_valid2, pixel2}, 0);
    reset = 1'b1;
    tick();

    // Row-0 prefill into bank 0, then read every column back.
    run_fill(9'd261, 0, -1, -1, 1'b0);
    for (int c = 0; c < 64; c++) begin
      pix_step(9'd0, 9'(c * 4 + c % 4), 1'b1, {1'b1, 8'(c)});
    end
    pix_step(9'd0, 9'd20, 1'b1, 9'h105);
    pix_step(9'd0, 9'd255, 1'b1, 9'h13F);
    pix_step(9'd0, 9'd256, 1'b1, 9'h000);
    pix_step(9'd0, 9'd300, 1'b1, 9'h000);
    pix_step(9'd0, 9'd20, 1'b0, 9'h000);
    pix_step(9'd256, 9'd20, 1'b1, 9'h000);

    // Lines 255..V_TOTAL-2 must not start a fill.
    display_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vpos = (i == 0) ? 9'd255 : ((i == 1) ? 9'd256 : 9'd260);
      hpos = 9'd0;
      tick();
      chk($sformatf("no_trig1 v%0d", vpos), {31'd0, fb_busy1}, 0);
      chk($sformatf("no_trig2 v%0d", vpos), {31'd0, fb_busy2}, 0);
      hpos = 9'd1;
      tick();
    end

    // Row advance: line 3 fetches row 1 into bank 1.
    run_fill(9'd3, 1, -1, -1, 1'b0);
    pix_step(9'd4, 9'd8, 1'b1, 9'h103);
    pix_step(9'd5, 9'd60, 1'b1, 9'h10E);
    pix_step(9'd0, 9'd8, 1'b1, 9'h102);

    // Overrun: second trigger 10 cycles into the fill.
    run_fill(9'd261, 0, 10, -1, 1'b1);
    display_on = 1'b0; vpos = 9'd100; hpos = 9'd1;
    for (int i = 0; i < 5; i++) tick();
    chk("ovr_sticky1", {31'd0, fill_overrun1}, 1);
    chk("ovr_sticky2", {31'd0, fill_overrun2}, 1);

    // Reset mid-fill, then a clean full fill.
    run_fill(9'd261, 0, -1, 30, 1'b0);
    vpos = 9'd100; hpos = 9'd1;
    tick();
    run_fill(9'd261, 0, -1, -1, 1'b0);
    pix_step(9'd0, 9'd20, 1'b1, 9'h105);
    pix_step(9'd7, 9'd252, 1'b1, 9'h13E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
